// File: rtl/int_to_single_sched.sv
// Shares one pipelined int-to-single converter between NUM_REQ requesters.
// Round-robin admission, a tag pipe that follows each conversion, and a stb/ack result port per requester.
module int_to_single_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*32-1:0] in_a,
  input  logic [NUM_REQ-1:0]    in_stb,
  output logic [NUM_REQ-1:0]    in_ack,
  output logic [NUM_REQ*32-1:0] out_z,
  output logic [NUM_REQ-1:0]    out_stb,
  input  logic [NUM_REQ-1:0]    out_ack,
  output logic [31:0]           conv_a,
  input  logic [31:0]           conv_z
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state [NUM_REQ];
  logic [PW-1:0]         r_ptr;
  logic                  r_tagValid [LATENCY+1];
  logic [PW-1:0]         r_tag [LATENCY+1];
  logic [31:0]           r_convA;
  logic [NUM_REQ*32-1:0] r_outZ;
  logic [NUM_REQ-1:0]    r_outStb;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_grantValid;
  logic [PW-1:0]         w_grantIdx;
  logic [PW-1:0]         w_ptrNext;
  logic [31:0]           w_grantA;

  function automatic logic [PW-1:0] wrapIdx(input int v);
    return PW'(v % NUM_REQ);
  endfunction

  // Only idle requesters may be admitted; nothing is granted while in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = in_stb[i] && (r_state[i] == IDLE) && !rst;
    end
  end

  // Scan downward so the last hit written is the first one at or after r_ptr.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig[wrapIdx(int'(r_ptr) + k)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = wrapIdx(int'(r_ptr) + k);
      end
    end
  end

  always_comb begin
    in_ack   = '0;
    w_grantA = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantValid && (w_grantIdx == PW'(i))) begin
        in_ack[i] = 1'b1;
        w_grantA  = in_a[32*i +: 32];
      end
    end
    w_ptrNext = (w_grantIdx == PW'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_convA  <= '0;
      r_outZ   <= '0;
      r_outStb <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_state[i] <= IDLE;
      end
      for (int k = 0; k <= LATENCY; k++) begin
        r_tagValid[k] <= 1'b0;
        r_tag[k]      <= '0;
      end
    end else begin
      r_tagValid[0] <= w_grantValid;
      r_tag[0]      <= w_grantIdx;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
        r_tag[k]      <= r_tag[k-1];
      end
      if (w_grantValid) begin
        r_convA <= w_grantA;
        r_ptr   <= w_ptrNext;
      end
      // Grant, capture and hand-off are mutually exclusive per requester by state.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grantValid && (w_grantIdx == PW'(i))) begin
          r_state[i] <= BUSY;
        end else if (r_tagValid[LATENCY] && (r_tag[LATENCY] == PW'(i))) begin
          r_state[i]          <= DONE;
          r_outStb[i]         <= 1'b1;
          r_outZ[32*i +: 32]  <= conv_z;
        end else if (r_outStb[i] && out_ack[i]) begin
          r_state[i]  <= IDLE;
          r_outStb[i] <= 1'b0;
        end
      end
    end
  end

  assign conv_a  = r_convA;
  assign out_z   = r_outZ;
  assign out_stb = r_outStb;

endmodule

// File: tb/tb_int_to_single_sched.sv
// Bench for int_to_single_sched: stands in for the 4-stage converter and checks every cycle
// against a transaction-level model, plus directed literal checks for the documented scenarios.
module tb_int_to_single_sched;

  localparam int N   = 4;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*32-1:0] in_a = '0;
  logic [N-1:0]   in_stb = '0;
  logic [N-1:0]   in_ack;
  logic [N*32-1:0] out_z;
  logic [N-1:0]   out_stb;
  logic [N-1:0]   out_ack = '0;
  logic [31:0]    conv_a;
  logic [31:0]    conv_z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int_to_single_sched #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_stb(in_stb), .in_ack(in_ack),
    .out_z(out_z), .out_stb(out_stb), .out_ack(out_ack),
    .conv_a(conv_a), .conv_z(conv_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference int32 -> IEEE-754 single with round-to-nearest-even.
  function automatic logic [31:0] toSingle(input logic [31:0] a);
    logic        s;
    logic [63:0] m, mant, rem, half;
    logic [7:0]  e;
    int          p, sh;
    if (a == 32'd0) return 32'd0;
    s = a[31];
    m = s ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    p = 0;
    for (int b = 0; b < 64; b++) if (m[b]) p = b;
    e = 8'(127 + p);
    if (p <= 23) begin
      mant = m << (23 - p);
    end else begin
      sh   = p - 23;
      mant = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 8'd1;
      end
    end
    return {s, e, mant[22:0]};
  endfunction

  // Converter stand-in: samples conv_a each edge, result appears LAT clocks later.
  logic [31:0] cPipe [LAT];
  always @(posedge clk) begin
    cPipe[0] <= toSingle(conv_a);
    for (int k = 1; k < LAT; k++) cPipe[k] <= cPipe[k-1];
  end
  assign conv_z = cPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 converting (result visible at mDue), 2 holding result.
  int          mPhase [N];
  int          mDue [N];
  logic [31:0] mVal [N];
  logic [31:0] mZ [N];
  int          mPtr = 0;
  int          mCyc = 0;

  always @(negedge clk) begin : monitor
    logic [N-1:0] expAck;
    int g, idx;
    expAck = '0;
    g = -1;
    if (rst) begin
      checkOutput("ackInReset", 32'(in_ack), 32'd0);
      for (int i = 0; i < N; i++) begin
        mPhase[i] = 0;
        mZ[i]     = 32'd0;
      end
      mPtr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if ((g < 0) && in_stb[idx] && (mPhase[idx] == 0)) g = idx;
      end
      if (g >= 0) expAck[g] = 1'b1;
      checkOutput("inAck", 32'(in_ack), 32'(expAck));
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("outStb%0d", i), 32'(out_stb[i]), 32'(mPhase[i] == 2));
        checkOutput($sformatf("outZ%0d", i), out_z[32*i +: 32], mZ[i]);
      end
      for (int i = 0; i < N; i++) begin
        if ((mPhase[i] == 2) && out_ack[i]) mPhase[i] = 0;
        else if ((mPhase[i] == 1) && (mDue[i] == mCyc + 1)) begin
          mPhase[i] = 2;
          mZ[i]     = mVal[i];
        end
      end
      if (g >= 0) begin
        mPhase[g] = 1;
        mDue[g]   = mCyc + LAT + 2;
        mVal[g]   = toSingle(in_a[32*g +: 32]);
        mPtr      = (g + 1) % N;
      end
    end
    mCyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] stb, input logic [N-1:0] ack);
    in_stb  = stb;
    out_ack = ack;
  endtask

  task automatic setA(input int i, input logic [31:0] v);
    in_a[32*i +: 32] = v;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitGrant(input int i, output int t);
    t = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ack[i]) begin
        t = cyc;
        return;
      end
    end
    checkOutput($sformatf("grantTimeout%0d", i), 32'd0, 32'd1);
  endtask

  task automatic waitStb(input logic [N-1:0] mask, output int t);
    t = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if ((out_stb & mask) == mask) begin
        t = cyc;
        return;
      end
    end
    checkOutput("stbTimeout", 32'(out_stb), 32'(mask));
  endtask

  initial begin : stimulus
    int t, ts, nz;
    int seq[$];
    int gcnt [N];

    // Reset: requests are raised to show in_ack stays low under reset.
    rst = 1'b1;
    applyStimulus('1, '0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("resetStb", 32'(out_stb), 32'd0);
    checkOutput("resetConvA", conv_a, 32'd0);
    checkOutput("resetZ0", out_z[31:0], 32'd0);
    tick();
    applyStimulus('0, '0);
    rst = 1'b0;
    tick();

    // Single requester, value 5.
    setA(0, 32'd5);
    applyStimulus(4'b0001, 4'b0000);
    waitGrant(0, t);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    waitStb(4'b0001, ts);
    checkOutput("t1Latency", 32'(ts), 32'(t + 6));
    checkOutput("t1Z", out_z[31:0], 32'h40A00000);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("t1Hold", 32'(out_stb[0]), 32'd1);
    tick();
    applyStimulus(4'b0000, 4'b0001);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("t1Released", 32'(out_stb[0]), 32'd0);
    checkOutput("t1ZKept", out_z[31:0], 32'h40A00000);
    tick();

    // All four together from ptr=0.
    doReset();
    for (int i = 0; i < N; i++) setA(i, 32'(i + 1));
    applyStimulus(4'hF, 4'h0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t2Grant%0d", k), 32'(in_ack), 32'd1 << k);
    end
    tick();
    applyStimulus(4'h0, 4'h0);
    waitStb(4'hF, ts);
    checkOutput("t2Z0", out_z[31:0],   32'h3F800000);
    checkOutput("t2Z1", out_z[63:32],  32'h40000000);
    checkOutput("t2Z2", out_z[95:64],  32'h40400000);
    checkOutput("t2Z3", out_z[127:96], 32'h40800000);
    tick();
    applyStimulus(4'h0, 4'hF);
    tick();
    applyStimulus(4'h0, 4'h0);

    // Requesters 0 and 2 continuously, acking at once: strict alternation every 7 cycles.
    doReset();
    setA(0, 32'd7);
    setA(2, 32'hFFFFFFFD);
    applyStimulus(4'b0101, 4'b0101);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ack != '0) seq.push_back(in_ack == 4'b0001 ? 0 : (in_ack == 4'b0100 ? 2 : 9));
    end
    checkOutput("t3Count", 32'(seq.size()), 32'd10);
    foreach (seq[k]) checkOutput($sformatf("t3Seq%0d", k), 32'(seq[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
    tick();
    applyStimulus(4'b0000, 4'b0101);
    repeat (10) tick();
    applyStimulus(4'b0000, 4'b0000);

    // Requester 1 never acks; the others keep going.
    doReset();
    setA(0, 32'd11);
    setA(1, 32'd100);
    setA(2, 32'd22);
    setA(3, 32'd33);
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    applyStimulus(4'hF, 4'b1101);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (in_ack[i]) gcnt[i]++;
    end
    checkOutput("t4Grants1", 32'(gcnt[1]), 32'd1);
    checkOutput("t4Grants0", 32'(gcnt[0]), 32'd6);
    checkOutput("t4Grants2", 32'(gcnt[2]), 32'd6);
    checkOutput("t4Grants3", 32'(gcnt[3]), 32'd6);
    checkOutput("t4Stb1", 32'(out_stb[1]), 32'd1);
    checkOutput("t4Z1", out_z[63:32], 32'h42C80000);
    tick();
    applyStimulus(4'h0, 4'hF);
    repeat (10) tick();
    applyStimulus(4'h0, 4'h0);

    // Reset two cycles after a grant discards the conversion.
    doReset();
    setA(3, 32'd9);
    applyStimulus(4'b1000, 4'b0000);
    waitGrant(3, t);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nz = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_stb != '0) nz++;
    end
    checkOutput("t5NoResult", 32'(nz), 32'd0);
    tick();

    // Edge operands.
    setA(0, 32'hFFFFFFFF);
    setA(1, 32'h00000000);
    setA(2, 32'h80000000);
    applyStimulus(4'b0111, 4'b0000);
    waitStb(4'b0111, ts);
    checkOutput("t6ZNeg1", out_z[31:0],  32'hBF800000);
    checkOutput("t6ZZero", out_z[63:32], 32'h00000000);
    checkOutput("t6ZMin",  out_z[95:64], 32'hCF000000);
    tick();
    applyStimulus(4'b0000, 4'b0111);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
